stream_min_max_tracker: RTL and testbench

//   Streaming consumer of word comparisons. Accepts a framed stream of unsigned words over

---
 rtl/stream_min_max_tracker_pkg.sv | 16 +
 rtl/stream_min_max_tracker_cmp.sv | 20 ++
 rtl/stream_min_max_tracker.sv | 159 +++++++++++++++
 tb/tb_stream_min_max_tracker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_min_max_tracker_pkg.sv
// Shared definitions for the stream min/max tracker.
//   state_t        : FSM encoding (IDLE / ACC / DONE)
//   DEF_WORD_SIZE  : default data word width
//   DEF_CNT_W      : default beat counter / index width
package stream_min_max_tracker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/stream_min_max_tracker_cmp.sv
// Unsigned magnitude comparator used by the stream min/max tracker.
//   A, B    : operands (unsigned, WORD_SIZE bits)
//   A_lt_B  : A < B
//   A_gt_B  : A > B
//   A_eq_B  : A == B
module word_magnitude_cmp #(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] B,
  output logic                 A_lt_B,
  output logic                 A_gt_B,
  output logic                 A_eq_B
);

  assign A_lt_B = (A < B);
  assign A_gt_B = (A > B);
  assign A_eq_B = (A == B);

endmodule

// File: rtl/stream_min_max_tracker.sv
// Stream min/max tracker: consumes a framed stream of unsigned words and, at
// end of frame, presents min/max values, their first-occurrence indices, the
// beat count, an all-equal flag and a counter-saturation flag.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : input beat handshake
//   out_valid/out_ready            : result record handshake
//   out_min/out_max                : extremes of the frame
//   out_min_idx/out_max_idx        : 0-based index of first occurrence
//   out_count                      : beats in frame (saturating)
//   out_all_eq                     : every beat equal
//   out_sat                        : beat counter saturated
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for first beat of a frame
// ACC    | accumulating beats, min/max tracking active
// DONE   | record presented, waiting for out_ready
module stream_min_max_tracker
  import stream_min_max_tracker_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_min,
  output logic [WORD_SIZE-1:0] out_max,
  output logic [CNT_W-1:0]     out_min_idx,
  output logic [CNT_W-1:0]     out_max_idx,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_all_eq,
  output logic                 out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               r_state;
  state_t               w_next;
  logic                 r_init;
  logic [WORD_SIZE-1:0] r_min;
  logic [WORD_SIZE-1:0] r_max;
  logic [CNT_W-1:0]     r_min_idx;
  logic [CNT_W-1:0]     r_max_idx;
  logic [CNT_W-1:0]     r_count;
  logic                 r_sat;

  logic w_accept;
  logic w_load_first;
  logic w_acc_beat;
  logic w_lt_min;
  logic w_gt_min;
  logic w_eq_min;
  logic w_lt_max;
  logic w_gt_max;
  logic w_eq_max;
  logic w_mm_lt;
  logic w_mm_gt;
  logic w_mm_eq;

  word_magnitude_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp_min (
    .A      (in_data),
    .B      (r_min),
    .A_lt_B (w_lt_min),
    .A_gt_B (w_gt_min),
    .A_eq_B (w_eq_min)
  );

  word_magnitude_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp_max (
    .A      (in_data),
    .B      (r_max),
    .A_lt_B (w_lt_max),
    .A_gt_B (w_gt_max),
    .A_eq_B (w_eq_max)
  );

  word_magnitude_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp_mm (
    .A      (r_min),
    .B      (r_max),
    .A_lt_B (w_mm_lt),
    .A_gt_B (w_mm_gt),
    .A_eq_B (w_mm_eq)
  );

  // in_ready must stay low while reset is held and only rise on the first
  // clock after release, so a one-bit flag records that a clock has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init  <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      r_init  <= 1'b1;
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = in_last ? S_DONE : S_ACC;
      S_ACC:  if (w_accept && in_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = r_init && (r_state != S_DONE);
    out_valid    = (r_state == S_DONE);
    w_accept     = in_valid && in_ready;
    w_load_first = w_accept && (r_state == S_IDLE);
    w_acc_beat   = w_accept && (r_state == S_ACC);
    // Held registers are stale in IDLE; suppress the flag so reset reads 0.
    out_all_eq   = w_mm_eq && (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
      r_sat     <= 1'b0;
    end else if (w_load_first) begin
      r_min     <= in_data;
      r_max     <= in_data;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= CNT_W'(1);
      r_sat     <= 1'b0;
    end else if (w_acc_beat) begin
      // The current count is this beat's index (clamped once saturated).
      if (w_lt_min) begin
        r_min     <= in_data;
        r_min_idx <= r_count;
      end
      if (w_gt_max) begin
        r_max     <= in_data;
        r_max_idx <= r_count;
      end
      if (r_count == CNT_MAX) r_sat   <= 1'b1;
      else                    r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_min     = r_min;
  assign out_max     = r_max;
  assign out_min_idx = r_min_idx;
  assign out_max_idx = r_max_idx;
  assign out_count   = r_count;
  assign out_sat     = r_sat;

endmodule

// File: tb/tb_stream_min_max_tracker.sv
module tb_stream_min_max_tracker;

  typedef struct {
    logic [31:0] min;
    logic [31:0] max;
    logic [15:0] min_idx;
    logic [15:0] max_idx;
    logic [15:0] count;
    logic        all_eq;
    logic        sat;
  } rec_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_min, out_max;
  logic [15:0] out_min_idx, out_max_idx, out_count;
  logic        out_all_eq, out_sat;

  // Narrow-counter instance for saturation checks.
  logic        in_valid3 = 0;
  logic        in_ready3;
  logic [31:0] in_data3 = '0;
  logic        in_last3 = 0;
  logic        out_valid3;
  logic [31:0] out_min3, out_max3;
  logic [2:0]  out_min_idx3, out_max_idx3, out_count3;
  logic        out_all_eq3, out_sat3;

  int n_checks = 0;
  int n_fail = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  stream_min_max_tracker #(.WORD_SIZE(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max),
    .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
    .out_count(out_count), .out_all_eq(out_all_eq), .out_sat(out_sat)
  );

  stream_min_max_tracker #(.WORD_SIZE(32), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(1'b1),
    .out_min(out_min3), .out_max(out_max3),
    .out_min_idx(out_min_idx3), .out_max_idx(out_max_idx3),
    .out_count(out_count3), .out_all_eq(out_all_eq3), .out_sat(out_sat3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] mn, input logic [15:0] mni,
                              input logic [31:0] mx, input logic [15:0] mxi,
                              input logic [15:0] cnt, input logic eq, input logic sat);
    rec_t r;
    r.min = mn; r.min_idx = mni; r.max = mx; r.max_idx = mxi;
    r.count = cnt; r.all_eq = eq; r.sat = sat;
    return r;
  endfunction

  // Monitor: a record handshake completes on the posedge following a negedge
  // where out_valid && out_ready; compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 1, 0);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          chk("min",     out_min,     e.min);
          chk("min_idx", out_min_idx, e.min_idx);
          chk("max",     out_max,     e.max);
          chk("max_idx", out_max_idx, e.max_idx);
          chk("count",   out_count,   e.count);
          chk("all_eq",  out_all_eq,  e.all_eq);
          chk("sat",     out_sat,     e.sat);
        end
      end
    end
  end

  // Called at posedge+1; presents a beat and returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 0;
    in_valid = 1; in_data = d; in_last = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_data = 'x; in_last = 0;
  endtask

  task automatic send3(input logic [31:0] d, input logic l);
    bit ok = 0;
    in_valid3 = 1; in_data3 = d; in_last3 = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready3) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready3_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid3 = 0; in_last3 = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_min",       out_min, 0);
    chk("rst_count",     out_count, 0);
    chk("rst_all_eq",    out_all_eq, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: mixed frame with ties
    exp_q.push_back(mk(3, 1, 9, 2, 5, 0, 0));
    send(5, 0); send(3, 0); send(9, 0); send(3, 0); send(9, 1);

    // 2: single beat, out_valid one cycle after presentation
    exp_q.push_back(mk(7, 0, 7, 0, 1, 1, 0));
    send(7, 1);
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    @(posedge clk); #1;

    // 3: back-pressure holds the record
    out_ready = 0;
    exp_q.push_back(mk(4, 0, 4, 0, 3, 1, 0));
    send(4, 0); send(4, 0); send(4, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold_in_ready",  in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_min",       out_min, 4);
      chk("hold_count",     out_count, 3);
    end
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_hold_out_valid", out_valid, 0);
    chk("after_hold_in_ready",  in_ready, 1);
    @(posedge clk); #1;

    // 4: unsigned extremes
    exp_q.push_back(mk(32'h0, 1, 32'hFFFF_FFFF, 0, 2, 0, 0));
    send(32'hFFFF_FFFF, 0); send(32'h0, 1);

    // 5: narrow counter saturation, descending data 10..1
    for (int i = 0; i < 10; i++) send3(32'(10 - i), (i == 9));
    @(negedge clk);
    chk("sat3_out_valid", out_valid3, 1);
    chk("sat3_count",     out_count3, 7);
    chk("sat3_sat",       out_sat3, 1);
    chk("sat3_min",       out_min3, 1);
    chk("sat3_min_idx",   out_min_idx3, 7);
    chk("sat3_max",       out_max3, 10);
    chk("sat3_max_idx",   out_max_idx3, 0);
    @(posedge clk); #1;

    // 6: reset mid-frame discards it
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    send(11, 0); send(1, 0);
    rst_n = 0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_min",       out_min, 0);
    chk("midrst_max",       out_max, 0);
    chk("midrst_count",     out_count, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    exp_q.push_back(mk(2, 1, 8, 0, 2, 0, 0));
    send(8, 0); send(2, 1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
